// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer and its adder.
package mdu_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Same codes the EX-stage ALU control uses
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/mdu_addsub.sv
// Combinational W-bit adder/subtractor shared by the multiply and divide datapaths.
module mdu_addsub
  import mdu_pkg::*;
#(
  parameter int W = 65
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_alu_op,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic         w_sub;
  logic [W-1:0] w_b;

  assign w_sub = (i_alu_op == ALU_SUB);
  assign w_b   = w_sub ? ~i_b : i_b;

  // Subtract as a + ~b + 1; carry out is 1 when a >= b
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, w_sub};

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit for the EX stage; stalls the pipe while running.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one shift-add / restoring-divide step per cycle
//   FIX   | divide by zero: quotient all ones, remainder rs1
//   DONE  | result valid, EX mux steered to it for one cycle
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int CNTW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            result_sel,
  output logic [XLEN-1:0] result
);

  state_t            r_state;
  logic [CNTW-1:0]   r_cnt;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic [2*XLEN-1:0] r_p;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_result;

  logic              w_is_div;
  logic [XLEN:0]     w_r_shift;
  logic [XLEN:0]     w_a;
  logic [XLEN:0]     w_b;
  logic [3:0]        w_alu_op;
  logic [XLEN:0]     w_sum;
  logic              w_carry;
  logic              w_div_ok;
  logic [2*XLEN-1:0] w_p_nxt;
  logic [XLEN:0]     w_rem_nxt;
  logic [XLEN-1:0]   w_q_nxt;
  logic [XLEN-1:0]   w_run_res;

  assign w_is_div  = r_op[1];
  assign w_r_shift = {r_rem[XLEN-1:0], r_q[XLEN-1]};
  assign w_a       = w_is_div ? w_r_shift : {1'b0, r_p[2*XLEN-1:XLEN]};
  assign w_b       = w_is_div ? {1'b0, r_rs2} : (r_p[0] ? {1'b0, r_rs1} : '0);
  assign w_alu_op  = w_is_div ? ALU_SUB : ALU_ADD;

  mdu_addsub #(.W(XLEN + 1)) u_addsub (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_alu_op (w_alu_op),
    .o_sum    (w_sum),
    .o_carry  (w_carry)
  );

  // R' < 2*rs2 always, so a clear sign bit and a carry out agree; both are used
  assign w_div_ok  = w_carry & ~w_sum[XLEN];
  assign w_p_nxt   = {w_sum, r_p[XLEN-1:1]};
  assign w_rem_nxt = w_div_ok ? w_sum : w_r_shift;
  assign w_q_nxt   = {r_q[XLEN-2:0], w_div_ok};

  always_comb begin
    w_run_res = w_p_nxt[XLEN-1:0];
    case (r_op)
      OP_MUL:   w_run_res = w_p_nxt[XLEN-1:0];
      OP_MULHU: w_run_res = w_p_nxt[2*XLEN-1:XLEN];
      OP_DIVU:  w_run_res = w_q_nxt;
      default:  w_run_res = w_rem_nxt[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_p      <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_result <= '0;
    end else if (kill) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_rs1   <= rs1_val;
            r_rs2   <= rs2_val;
            r_p     <= {{XLEN{1'b0}}, rs2_val};
            r_rem   <= '0;
            r_q     <= rs1_val;
            r_cnt   <= CNTW'(XLEN - 1);
            r_state <= (op[1] && rs2_val == '0) ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_is_div) begin
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
          end else begin
            r_p <= w_p_nxt;
          end
          if (r_cnt == '0) begin
            r_result <= w_run_res;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          r_result <= (r_op == OP_DIVU) ? '1 : r_rs1;
          r_state  <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign stall      = ((r_state == ST_IDLE) & start & ~kill) | (r_state == ST_RUN) | (r_state == ST_FIX);
  assign done       = (r_state == ST_DONE);
  assign result_sel = (r_state == ST_DONE);
  assign result     = r_result;

endmodule
